// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, function
// codes, ALU operation codes, the sequencer state enum and the control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,  ALU_OR   = 4'd1,  ALU_ADD  = 4'd2,  ALU_SUB  = 4'd3,
        ALU_SLT  = 4'd4,  ALU_NOR  = 4'd5,  ALU_XOR  = 4'd6,  ALU_LUI  = 4'd7,
        ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_SLLV = 4'd11,
        ALU_SRLV = 4'd12, ALU_SRAV = 4'd13
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
        S_WB_MEM = 4'd4,  S_MEM_WR = 4'd5,  S_EXEC_R   = 4'd6, S_WB_R   = 4'd7,
        S_EXEC_I = 4'd8,  S_WB_I   = 4'd9,  S_BRANCH   = 4'd10, S_JUMP  = 4'd11,
        S_JR     = 4'd12
    } state_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       data_c;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_e    alu_op;
        logic       signed_imm;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/aluop_decoder.sv
// Maps (opcode, func) to the ALU operation, immediate extension and a
// validity flag that the sequencer uses to reject undecodable instructions.
module aluop_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output alu_op_e    alu_op,
    output logic       signed_imm,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        alu_op     = ALU_ADD;
        signed_imm = 1'b0;
        valid      = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:         alu_op = ALU_AND;
                    F_OR:          alu_op = ALU_OR;
                    F_XOR:         alu_op = ALU_XOR;
                    F_NOR:         alu_op = ALU_NOR;
                    F_SLT, F_SLTU: alu_op = ALU_SLT;
                    F_SLL:         alu_op = ALU_SLL;
                    F_SRL:         alu_op = ALU_SRL;
                    F_SRA:         alu_op = ALU_SRA;
                    F_SLLV:        alu_op = ALU_SLLV;
                    F_SRLV:        alu_op = ALU_SRLV;
                    F_SRAV:        alu_op = ALU_SRAV;
                    F_JR:          alu_op = ALU_ADD;
                    default:       valid  = 1'b0;
                endcase
            end
            OP_ADDI:  begin alu_op = ALU_ADD; signed_imm = 1'b1; end
            OP_ADDIU: alu_op = ALU_ADD;
            OP_SLTI:  begin alu_op = ALU_SLT; signed_imm = 1'b1; end
            OP_SLTIU: alu_op = ALU_SLT;
            OP_ANDI:  alu_op = ALU_AND;
            OP_ORI:   alu_op = ALU_OR;
            OP_XORI:  alu_op = ALU_XOR;
            OP_LUI:   alu_op = ALU_LUI;
            OP_LW, OP_SW: begin alu_op = ALU_ADD; signed_imm = 1'b1; end
            OP_BEQ, OP_BNE: alu_op = ALU_SUB;
            OP_J, OP_JAL:   alu_op = ALU_ADD;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: steps the shared ALU and memory port through
// fetch/decode/execute/memory/write-back and drives every datapath select.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic               mem_to_reg,
    output logic               data_c,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               signed_imm,
    output logic [1:0]         pc_src,
    output logic               illegal,
    output logic [3:0]         state
);

    state_e  state_q;
    alu_op_e dec_op;
    logic    dec_signed;
    logic    dec_valid;
    ctrl_t   ctrl;

    aluop_decoder u_aluop_decoder (
        .opcode     (opcode),
        .func       (func),
        .alu_op     (dec_op),
        .signed_imm (dec_signed),
        .valid      (dec_valid)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    if (!dec_valid) begin
                        state_q <= S_FETCH;
                    end else begin
                        case (opcode)
                            OP_LW, OP_SW:   state_q <= S_MEM_ADDR;
                            OP_RTYPE:       state_q <= (func == F_JR) ? S_JR : S_EXEC_R;
                            OP_BEQ, OP_BNE: state_q <= S_BRANCH;
                            OP_J, OP_JAL:   state_q <= S_JUMP;
                            default:        state_q <= S_EXEC_I;
                        endcase
                    end
                end
                S_MEM_ADDR: state_q <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_ready) state_q <= S_WB_MEM;
                S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
                S_EXEC_R:   state_q <= S_WB_R;
                S_EXEC_I:   state_q <= S_WB_I;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // Outputs decode from the state register; a few are Mealy terms, and
    // reset overrides everything so an abandoned request fires nothing.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = 2'b11;
                ctrl.signed_imm = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal    = !dec_valid;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.signed_imm = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = dec_op;
            end
            S_WB_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 2'b01;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.alu_op     = dec_op;
                ctrl.signed_imm = dec_signed;
            end
            S_WB_I: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.pc_write  = (opcode == OP_BNE) ? !zero : zero;
            end
            S_JUMP: begin
                ctrl.pc_src   = 2'b10;
                ctrl.pc_write = 1'b1;
                if (opcode == OP_JAL) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 2'b10;
                    ctrl.data_c    = 1'b1;
                end
            end
            S_JR: begin
                ctrl.pc_src   = 2'b11;
                ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
        if (!rst) ctrl = '0;
    end

    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign i_or_d     = ctrl.i_or_d;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign data_c     = ctrl.data_c;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ALUOP_W'(ctrl.alu_op);
    assign signed_imm = ctrl.signed_imm;
    assign pc_src     = ctrl.pc_src;
    assign illegal    = ctrl.illegal;
    assign state      = rst ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is expanded into a per-cycle list of
// expected control words from the instruction's phase sequence and compared.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg, data_c, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       signed_imm;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg, data_c, alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       signed_imm;
        logic [1:0] pc_src;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       z;
        obs_t       exp;
    } step_t;

    step_t plan[$];
    obs_t  obs;

    assign obs = {state, mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
                  reg_dst, mem_to_reg, data_c, alu_src_a, alu_src_b, alu_op,
                  signed_imm, pc_src, illegal};

    multicycle_controller #(.ALUOP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func       (func),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .data_c     (data_c),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .signed_imm (signed_imm),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic obs_t base(input int st);
        obs_t o = '0;
        o.state = 4'(st);
        return o;
    endfunction

    function automatic obs_t fetch_obs(input logic rdy);
        obs_t o = base(0);
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'b01;
        o.alu_op    = 4'b0010;
        o.ir_write  = rdy;
        o.pc_write  = rdy;
        return o;
    endfunction

    // {valid, alu code} for an R-type function field
    function automatic logic [4:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 5'b1_0010;
            6'h22, 6'h23: return 5'b1_0011;
            6'h24:        return 5'b1_0000;
            6'h25:        return 5'b1_0001;
            6'h26:        return 5'b1_0110;
            6'h27:        return 5'b1_0101;
            6'h2a, 6'h2b: return 5'b1_0100;
            6'h00:        return 5'b1_1000;
            6'h02:        return 5'b1_1001;
            6'h03:        return 5'b1_1010;
            6'h04:        return 5'b1_1011;
            6'h06:        return 5'b1_1100;
            6'h07:        return 5'b1_1101;
            default:      return 5'b0_0000;
        endcase
    endfunction

    // {valid, signed, alu code} for an I-type arithmetic opcode
    function automatic logic [5:0] i_alu(input logic [5:0] op);
        case (op)
            6'h08:   return 6'b11_0010;
            6'h09:   return 6'b10_0010;
            6'h0a:   return 6'b11_0100;
            6'h0b:   return 6'b10_0100;
            6'h0c:   return 6'b10_0000;
            6'h0d:   return 6'b10_0001;
            6'h0e:   return 6'b10_0110;
            6'h0f:   return 6'b10_0111;
            default: return 6'b00_0000;
        endcase
    endfunction

    function automatic void push(input logic [5:0] op, input logic [5:0] fn,
                                 input logic rdy, input logic z, input obs_t e);
        step_t s;
        s.op = op; s.fn = fn; s.rdy = rdy; s.z = z; s.exp = e;
        plan.push_back(s);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Expand one instruction into expected cycles: fw/mw are wait cycles
    // before mem_ready in fetch and in the data-memory phase, zb is the
    // zero flag presented during a branch compare.
    function automatic void plan_instr(input logic [5:0] op, input logic [5:0] fn,
                                       input int fw, input int mw, input logic zb);
        obs_t o;
        logic legal;
        for (int i = 0; i < fw; i++) push(op, fn, 1'b0, rb(), fetch_obs(1'b0));
        push(op, fn, 1'b1, rb(), fetch_obs(1'b1));
        legal = (op == 6'h00 && (r_alu(fn) != 5'b0 || fn == 6'h08)) || i_alu(op)[5] ||
                op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h05 ||
                op == 6'h02 || op == 6'h03;
        o = base(1);
        o.alu_src_b = 2'b11; o.signed_imm = 1'b1; o.alu_op = 4'b0010;
        o.illegal = !legal;
        push(op, fn, rb(), rb(), o);
        if (!legal) return;
        if (op == 6'h23 || op == 6'h2b) begin
            o = base(2);
            o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.signed_imm = 1'b1; o.alu_op = 4'b0010;
            push(op, fn, rb(), rb(), o);
            o = base(op == 6'h23 ? 3 : 5);
            o.i_or_d = 1'b1;
            if (op == 6'h23) o.mem_read = 1'b1; else o.mem_write = 1'b1;
            for (int i = 0; i < mw; i++) push(op, fn, 1'b0, rb(), o);
            push(op, fn, 1'b1, rb(), o);
            if (op == 6'h23) begin
                o = base(4);
                o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
                push(op, fn, rb(), rb(), o);
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            o = base(12);
            o.pc_src = 2'b11; o.pc_write = 1'b1;
            push(op, fn, rb(), rb(), o);
        end else if (op == 6'h00) begin
            o = base(6);
            o.alu_src_a = 1'b1; o.alu_op = r_alu(fn)[3:0];
            push(op, fn, rb(), rb(), o);
            o = base(7);
            o.reg_write = 1'b1; o.reg_dst = 2'b01;
            push(op, fn, rb(), rb(), o);
        end else if (op == 6'h04 || op == 6'h05) begin
            o = base(10);
            o.alu_src_a = 1'b1; o.alu_op = 4'b0011; o.pc_src = 2'b01;
            o.pc_write = (op == 6'h05) ? !zb : zb;
            push(op, fn, rb(), zb, o);
        end else if (op == 6'h02 || op == 6'h03) begin
            o = base(11);
            o.pc_src = 2'b10; o.pc_write = 1'b1;
            if (op == 6'h03) begin
                o.reg_write = 1'b1; o.reg_dst = 2'b10; o.data_c = 1'b1;
            end
            push(op, fn, rb(), rb(), o);
        end else begin
            o = base(8);
            o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
            o.alu_op = i_alu(op)[3:0]; o.signed_imm = i_alu(op)[4];
            push(op, fn, rb(), rb(), o);
            o = base(9);
            o.reg_write = 1'b1;
            push(op, fn, rb(), rb(), o);
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic run_plan(input string name, input int limit);
        step_t s;
        int n = 0;
        while (plan.size() > 0 && n < limit) begin
            s = plan.pop_front();
            @(negedge clk);
            opcode = s.op; func = s.fn; mem_ready = s.rdy; zero = s.z;
            #2;
            compared++;
            if (obs !== s.exp) begin
                mismatched++;
                $display("FAIL %s cycle %0d: got %h want %h", name, n, obs, s.exp);
            end
            n++;
        end
        plan.delete();
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1; zero = 1'b1;
        #2;
        compared++;
        if (obs !== obs_t'(0)) begin
            mismatched++;
            $display("FAIL %s_asserted: got %h want %h", name, obs, obs_t'(0));
        end
        @(negedge clk);
        #2;
        compared++;
        if (obs !== obs_t'(0)) begin
            mismatched++;
            $display("FAIL %s_held: got %h want %h", name, obs, obs_t'(0));
        end
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        compared++;
        if (obs !== fetch_obs(1'b0)) begin
            mismatched++;
            $display("FAIL %s_release: got %h want %h", name, obs, fetch_obs(1'b0));
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_rtype_add();
        plan_instr(6'h00, 6'h20, 0, 0, 1'b0);
        run_plan("rtype_add", 1000);
    endtask

    task automatic test_lw_wait();
        plan_instr(6'h23, 6'h00, 0, 2, 1'b0);
        run_plan("lw_wait", 1000);
    endtask

    task automatic test_branches();
        plan_instr(6'h04, 6'h00, 0, 0, 1'b1);
        run_plan("beq_taken", 1000);
        plan_instr(6'h05, 6'h00, 0, 0, 1'b1);
        run_plan("bne_not_taken", 1000);
        plan_instr(6'h05, 6'h00, 1, 0, 1'b0);
        run_plan("bne_taken", 1000);
    endtask

    task automatic test_jumps();
        plan_instr(6'h03, 6'h00, 0, 0, 1'b0);
        run_plan("jal", 1000);
        plan_instr(6'h00, 6'h08, 0, 0, 1'b0);
        run_plan("jr", 1000);
    endtask

    task automatic test_illegal();
        plan_instr(6'h3f, 6'h00, 0, 0, 1'b0);
        run_plan("illegal_op", 1000);
        plan_instr(6'h00, 6'h01, 0, 0, 1'b0);
        run_plan("illegal_func", 1000);
        plan_instr(6'h00, 6'h20, 0, 0, 1'b0);
        run_plan("after_illegal", 1000);
    endtask

    task automatic test_mid_reset();
        plan_instr(6'h2b, 6'h00, 0, 3, 1'b0);
        run_plan("mid_reset_pre", 4);
        do_reset("mid_reset");
        plan_instr(6'h2b, 6'h00, 0, 0, 1'b0);
        run_plan("mid_reset_resume", 1000);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                                 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h00};
        logic [5:0] fns [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                 6'h08, 6'h20};
        logic [5:0] op, fn;
        for (int i = 0; i < 120; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 17)];
            plan_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rb());
            run_plan($sformatf("random_%0d_op%02h_fn%02h", i, op, fn), 1000);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_lw_wait();
        test_branches();
        test_jumps();
        test_illegal();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the MIPS datapath. It replaces per-instruction combinational decode with a Moore/Mealy FSM that steps one shared ALU and one shared memory port through the fetch, decode, execute, memory and write-back phases. It sits beside the datapath: it takes `opcode`/`func` from the instruction register, the ALU `zero` flag and the memory `mem_ready` handshake, and drives every mux select and write enable.

## Interface
- `ALUOP_W`, 4, width of the ALU operation code.
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `opcode` in 6: IR[31:26].
- `func` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_read`, `mem_write` out 1 each: memory request; held until `mem_ready`.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `reg_write` out 1 each: write enables.
- `reg_dst` out 2: write register select; 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg`, `data_c` out 1 each: write-data select; `data_c` selects PC for `jal`.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- `alu_op` out `ALUOP_W`: ALU operation code.
- `signed_imm` out 1: 1 = sign-extend, 0 = zero-extend.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `state` out 4: current state, for debug.

## Operation
**States and encodings**
- FETCH = 0
- DECODE = 1
- MEM_ADDR = 2
- MEM_RD = 3
- WB_MEM = 4
- MEM_WR = 5
- EXEC_R = 6
- WB_R = 7
- EXEC_I = 8
- WB_I = 9
- BRANCH = 10
- JUMP = 11
- JR = 12

**Per-state behaviour.** Every output not listed below is 0.
- **FETCH:** `mem_read`=1, `alu_src_b`=01, `alu_op`=add. `ir_write` and `pc_write` are Mealy outputs equal to `mem_ready`. Stay until `mem_ready`, then go to DECODE.
- **DECODE:** `alu_src_b`=11, `signed_imm`=1, `alu_op`=add (branch target into ALUOut). Dispatch:
  - lw/sw → MEM_ADDR
  - R-type with `func`=001000 → JR
  - other R-type → EXEC_R
  - addi, addiu, slti, sltiu, andi, ori, xori, lui → EXEC_I
  - beq/bne → BRANCH
  - j/jal → JUMP
  - anything else → assert `illegal` for one cycle, then FETCH
- **MEM_ADDR:** `alu_src_a`=1, `alu_src_b`=10, `signed_imm`=1, `alu_op`=add. Go to MEM_RD for lw, MEM_WR for sw.
- **MEM_RD:** `mem_read`=1, `i_or_d`=1. Wait for `mem_ready`, then WB_MEM.
- **WB_MEM:** `reg_write`=1, `mem_to_reg`=1, `reg_dst`=00. Go to FETCH.
- **MEM_WR:** `mem_write`=1, `i_or_d`=1. Wait for `mem_ready`, then FETCH.
- **EXEC_R:** `alu_src_a`=1, `alu_src_b`=00, `alu_op` from `func`. An unknown `func` is caught in DECODE.
- **WB_R:** `reg_write`=1, `reg_dst`=01.
- **EXEC_I:** `alu_src_a`=1, `alu_src_b`=10, `alu_op` from `opcode`. `signed_imm`=1 for addi and slti only.
- **WB_I:** `reg_write`=1, `reg_dst`=00.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=sub, `pc_src`=01. `pc_write` = `zero` for beq, `!zero` for bne. Go to FETCH.
- **JUMP:** `pc_src`=10, `pc_write`=1. For jal also `reg_write`=1, `reg_dst`=10, `data_c`=1. Go to FETCH.
- **JR:** `pc_src`=11, `pc_write`=1. Go to FETCH.

**ALU operation codes**
- and 0000
- or 0001
- add/addu 0010
- sub/subu 0011
- slt/sltu 0100
- nor 0101
- xor 0110
- lui 0111
- sll 1000
- srl 1001
- sra 1010
- sllv 1011
- srlv 1100
- srav 1101

## Timing
- **Reset:** `rst`=0 at a rising edge forces FETCH. While `rst`=0, all outputs are forced to 0, including Mealy outputs and `illegal`. A reset mid-memory-request abandons the request; no write enable fires in that cycle.
- **`opcode`/`func` stability:** sampled in DECODE and later states. The IR holds them stable from the FETCH `ir_write` onward.
- **Latency with 1-cycle memory (`mem_ready` high on the first request cycle):**
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type: 4 cycles
  - beq/bne: 3 cycles
  - j/jal/jr: 3 cycles
  - Each extra wait cycle adds one cycle per memory state.
- **Memory handshake:** `mem_read`/`mem_write` are never asserted together. Each stays high until the cycle `mem_ready`=1. `mem_ready` is ignored in states that make no request.

## Structure
- **Shared package `mips_pkg`:** opcode and function-code constants, ALU operation codes, and the state enum.
- **Sub-module `aluop_decoder`:** combinational mapping of (`opcode`, `func`) to (`alu_op`, `signed_imm`, `valid`). DECODE uses `valid` to raise `illegal`.

## Test plan
- **R-type add:** `opcode`=000000, `func`=100000, `mem_ready`=1 → state sequence 0,1,6,7,0; `alu_op`=0010 in EXEC_R; `reg_write`=1 with `reg_dst`=01 in WB_R.
- **lw with memory wait:** lw with `mem_ready` low 2 cycles in MEM_RD → `mem_read` and `i_or_d` held high 3 cycles; WB_MEM has `mem_to_reg`=1; 7 cycles total.
- **Branches:** beq with `zero`=1 → `pc_write`=1, `pc_src`=01. bne with `zero`=1 → `pc_write`=0.
- **Jumps:** jal → JUMP with `reg_dst`=10, `data_c`=1, `reg_write`=1, `pc_write`=1. jr (`func`=001000) → `pc_src`=11.
- **Illegal opcode:** `opcode`=111111 → `illegal` high exactly one cycle in DECODE, next state FETCH, no write enables.
- **Reset mid-operation:** `rst` low during MEM_WR → `mem_write`=0 immediately; state 0 after the edge; FETCH resumes when `rst` returns high.
